// File: rtl/tt_bist_harness.sv
// tt_bist_harness: built-in self-test wrapper for a Tiny Tapeout user design.
// A Galois LFSR drives pseudo-random vectors into the wrapped core. The core's
// responses are folded into a MISR, and the final signature is compared
// against a golden value.
// Optional feature macro: BIST_XMASK_EN adds an xmask input. Masked response
// bits are then excluded from the signature.
module tt_bist_harness #(
    parameter int               WIDTH = 8,
    parameter int               LEN   = 256,
    parameter int               LAT   = 1,
    parameter logic [WIDTH-1:0] POLY  = 8'h1D,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] expected,
    input  logic [WIDTH-1:0] resp,
`ifdef BIST_XMASK_EN
    input  logic [WIDTH-1:0] xmask,
`endif
    output logic [WIDTH-1:0] stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    // An all-zero seed would lock the LFSR at zero, so it is promoted to 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] misr;
    logic [WIDTH-1:0] misr_next;
    logic [WIDTH-1:0] resp_eff;
    logic [15:0]      vec_cnt;
    logic [2:0]       drain_cnt;
    logic             run_last;
    logic             drain_last;
    logic             start_go;
    logic             finish;
    logic             run_now;
    logic             tag;

    // The LFSR and the MISR share this Galois shift-and-feedback step.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], 1'b0} ^ (x[WIDTH-1] ? POLY : '0);
    endfunction

`ifdef BIST_XMASK_EN
    assign resp_eff = resp & ~xmask;
`else
    assign resp_eff = resp;
`endif

    assign run_now    = (state == RUN);
    assign run_last   = (vec_cnt == 16'(LEN - 1));
    assign drain_last = (drain_cnt == 3'(LAT - 1));
    assign start_go   = start && ((state == IDLE) || (state == DONE));
    assign misr_next  = step(misr) ^ resp_eff;

    // The state register. Reset aborts any run and returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The finish strobe marks the edge that enters DONE.
    always_comb begin
        state_next = state;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (run_last) begin
                    if (LAT == 0) begin
                        state_next = DONE;
                        finish     = 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Each driven vector is tagged, and the tag is delayed by the core's
    // latency. Its response is compressed exactly when that response is valid.
    generate
        if (LAT == 0) begin : g_tag_direct
            assign tag = run_now;
        end else begin : g_tag_pipe
            logic [LAT-1:0] valid_sr;

            // The valid pipeline is cleared on reset and on every new run.
            always_ff @(posedge clk) begin
                if (rst || start_go) begin
                    valid_sr <= '0;
                end else begin
                    valid_sr <= LAT'({valid_sr, run_now});
                end
            end

            assign tag = valid_sr[LAT-1];
        end
    endgenerate

    // Datapath: stimulus generation, vector and drain counting, compression,
    // and the registered pass verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= SEED_EFF;
            misr      <= '0;
            vec_cnt   <= '0;
            drain_cnt <= '0;
            pass      <= 1'b0;
        end else if (start_go) begin
            lfsr      <= SEED_EFF;
            misr      <= '0;
            vec_cnt   <= '0;
            drain_cnt <= '0;
            pass      <= 1'b0;
        end else begin
            if (state == RUN) begin
                lfsr    <= step(lfsr);
                vec_cnt <= vec_cnt + 16'd1;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
            if (tag) begin
                misr <= misr_next;
            end
            if (finish) begin
                pass <= (misr_next == expected);
            end
        end
    end

    assign stim      = run_now ? lfsr : '0;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign signature = misr;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Directed testbench for tt_bist_harness. Several instances with different
// LEN/LAT settings run the hand-computed scenarios.
// Optional feature macro: BIST_XMASK_EN enables the response-masking scenario.
module tb_tt_bist_harness;

    localparam int N = 7;

    // Instance map: 0:LEN10 1:LEN1 2:LEN2 3:LEN4 4:LEN8 (all LAT1),
    // 5:LEN2/LAT0, 6:LEN2/LAT3
    function automatic int len_of(input int i);
        case (i)
            0: return 10;
            1: return 1;
            2: return 2;
            3: return 4;
            4: return 8;
            default: return 2;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        case (i)
            5: return 0;
            6: return 3;
            default: return 1;
        endcase
    endfunction

    logic       clk;
    logic       rst_s   [N];
    logic       start_s [N];
    logic [7:0] exp_s   [N];
    logic [7:0] resp_s  [N];
    logic [7:0] xmask_s [N];
    logic [7:0] stim_s  [N];
    logic       busy_s  [N];
    logic       done_s  [N];
    logic       pass_s  [N];
    logic [7:0] sig_s   [N];

    int checks;
    int failures;

    for (genvar g = 0; g < N; g++) begin : g_dut
        tt_bist_harness #(
            .WIDTH(8),
            .LEN  (len_of(g)),
            .LAT  (lat_of(g)),
            .POLY (8'h1D),
            .SEED (8'h01)
        ) u_dut (
            .clk      (clk),
            .rst      (rst_s[g]),
            .start    (start_s[g]),
            .expected (exp_s[g]),
            .resp     (resp_s[g]),
`ifdef BIST_XMASK_EN
            .xmask    (xmask_s[g]),
`endif
            .stim     (stim_s[g]),
            .busy     (busy_s[g]),
            .done     (done_s[g]),
            .pass     (pass_s[g]),
            .signature(sig_s[g])
        );
    end

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle. Sampling and driving happen 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic st, input logic [7:0] rsp,
                                 input logic [7:0] expd, input logic [7:0] msk);
        start_s[i] = st;
        resp_s[i]  = rsp;
        exp_s[i]   = expd;
        xmask_s[i] = msk;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, required %0h", tag, obs, expv);
        end
    endtask

    // Issue a one-cycle start. On return the bench sits in cycle T+1.
    task automatic kick(input int i);
        start_s[i] = 1'b1;
        tick();
        start_s[i] = 1'b0;
    endtask

    logic [7:0] lfsr_exp [10];

    initial begin
        checks   = 0;
        failures = 0;
        lfsr_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
        for (int i = 0; i < N; i++) begin
            rst_s[i] = 1'b1;
            applyStimulus(i, 1'b0, 8'h00, 8'h00, 8'h00);
        end
        tick();
        tick();
        for (int i = 0; i < N; i++) rst_s[i] = 1'b0;

        // Reset values on every instance.
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("rst_stim%0d", i), 32'(stim_s[i]), 32'h0);
            checkOutput($sformatf("rst_busy%0d", i), 32'(busy_s[i]), 32'h0);
            checkOutput($sformatf("rst_done%0d", i), 32'(done_s[i]), 32'h0);
            checkOutput($sformatf("rst_pass%0d", i), 32'(pass_s[i]), 32'h0);
            checkOutput($sformatf("rst_sig%0d", i), 32'(sig_s[i]), 32'h0);
        end

        // LFSR sequence: LEN=10, resp=0.
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 8'h00);
        kick(0);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("lfsr_stim_v%0d", k + 1), 32'(stim_s[0]), 32'(lfsr_exp[k]));
            checkOutput($sformatf("lfsr_busy_v%0d", k + 1), 32'(busy_s[0]), 32'h1);
            if (k < 9) tick();
        end
        tick();
        checkOutput("lfsr_drain_stim", 32'(stim_s[0]), 32'h0);
        checkOutput("lfsr_drain_busy", 32'(busy_s[0]), 32'h1);
        checkOutput("lfsr_drain_done", 32'(done_s[0]), 32'h0);
        tick();
        checkOutput("lfsr_done", 32'(done_s[0]), 32'h1);
        checkOutput("lfsr_busy_end", 32'(busy_s[0]), 32'h0);
        checkOutput("lfsr_sig", 32'(sig_s[0]), 32'h00);
        checkOutput("lfsr_pass", 32'(pass_s[0]), 32'h1);

        // Single-vector MISR: LEN=1, resp=01, done at T+3.
        applyStimulus(1, 1'b0, 8'h01, 8'h01, 8'h00);
        kick(1);
        checkOutput("one_stim", 32'(stim_s[1]), 32'h01);
        tick();
        checkOutput("one_t2_busy", 32'(busy_s[1]), 32'h1);
        checkOutput("one_t2_done", 32'(done_s[1]), 32'h0);
        tick();
        checkOutput("one_t3_done", 32'(done_s[1]), 32'h1);
        checkOutput("one_sig", 32'(sig_s[1]), 32'h01);
        checkOutput("one_pass", 32'(pass_s[1]), 32'h1);

        // Two-vector MISR: expected 03 passes, then a rerun with 02 fails.
        applyStimulus(2, 1'b0, 8'h01, 8'h03, 8'h00);
        kick(2);
        tick();
        tick();
        tick();
        checkOutput("two_done", 32'(done_s[2]), 32'h1);
        checkOutput("two_sig", 32'(sig_s[2]), 32'h03);
        checkOutput("two_pass_good", 32'(pass_s[2]), 32'h1);
        applyStimulus(2, 1'b0, 8'h01, 8'h02, 8'h00);
        kick(2);
        checkOutput("two_rerun_done_clr", 32'(done_s[2]), 32'h0);
        checkOutput("two_rerun_pass_clr", 32'(pass_s[2]), 32'h0);
        checkOutput("two_rerun_sig_clr", 32'(sig_s[2]), 32'h0);
        tick();
        tick();
        tick();
        checkOutput("two_rerun_sig", 32'(sig_s[2]), 32'h03);
        checkOutput("two_pass_bad", 32'(pass_s[2]), 32'h0);

        // Start while busy is ignored. LEN=4, resp=5A, signature 71.
        applyStimulus(3, 1'b0, 8'h5A, 8'h71, 8'h00);
        kick(3);
        tick();
        start_s[3] = 1'b1;
        tick();
        start_s[3] = 1'b0;
        checkOutput("busy_t3_stim", 32'(stim_s[3]), 32'h04);
        tick();
        tick();
        checkOutput("busy_t5_done", 32'(done_s[3]), 32'h0);
        checkOutput("busy_t5_busy", 32'(busy_s[3]), 32'h1);
        tick();
        checkOutput("busy_t6_done", 32'(done_s[3]), 32'h1);
        checkOutput("busy_sig", 32'(sig_s[3]), 32'h71);
        checkOutput("busy_pass", 32'(pass_s[3]), 32'h1);
        kick(3);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("rerun_done", 32'(done_s[3]), 32'h1);
        checkOutput("rerun_sig", 32'(sig_s[3]), 32'h71);
        checkOutput("rerun_pass", 32'(pass_s[3]), 32'h1);

        // Reset mid-run at T+2 of a LEN=8 run.
        applyStimulus(4, 1'b0, 8'h01, 8'h00, 8'h00);
        kick(4);
        tick();
        rst_s[4] = 1'b1;
        tick();
        rst_s[4] = 1'b0;
        checkOutput("abort_stim", 32'(stim_s[4]), 32'h0);
        checkOutput("abort_busy", 32'(busy_s[4]), 32'h0);
        checkOutput("abort_sig", 32'(sig_s[4]), 32'h0);
        checkOutput("abort_done", 32'(done_s[4]), 32'h0);
        // Reset later in a run discards a non-zero partial signature.
        kick(4);
        for (int k = 0; k < 4; k++) tick();
        checkOutput("abort2_partial_sig", 32'(sig_s[4]), 32'h07);
        rst_s[4] = 1'b1;
        tick();
        rst_s[4] = 1'b0;
        checkOutput("abort2_sig", 32'(sig_s[4]), 32'h0);
        checkOutput("abort2_busy", 32'(busy_s[4]), 32'h0);

        // Zero latency: the response is compressed in the cycle it is driven.
        applyStimulus(5, 1'b0, 8'h01, 8'h03, 8'h00);
        kick(5);
        checkOutput("lat0_stim1", 32'(stim_s[5]), 32'h01);
        tick();
        checkOutput("lat0_stim2", 32'(stim_s[5]), 32'h02);
        checkOutput("lat0_sig_partial", 32'(sig_s[5]), 32'h01);
        tick();
        checkOutput("lat0_done", 32'(done_s[5]), 32'h1);
        checkOutput("lat0_busy", 32'(busy_s[5]), 32'h0);
        checkOutput("lat0_sig", 32'(sig_s[5]), 32'h03);
        checkOutput("lat0_pass", 32'(pass_s[5]), 32'h1);

        // Three-cycle latency: busy spans T+1..T+5 and done arrives at T+6.
        applyStimulus(6, 1'b0, 8'h01, 8'h03, 8'h00);
        kick(6);
        tick();
        tick();
        checkOutput("lat3_drain_stim", 32'(stim_s[6]), 32'h0);
        checkOutput("lat3_sig_t3", 32'(sig_s[6]), 32'h00);
        tick();
        tick();
        checkOutput("lat3_t5_busy", 32'(busy_s[6]), 32'h1);
        checkOutput("lat3_t5_done", 32'(done_s[6]), 32'h0);
        tick();
        checkOutput("lat3_done", 32'(done_s[6]), 32'h1);
        checkOutput("lat3_sig", 32'(sig_s[6]), 32'h03);
        checkOutput("lat3_pass", 32'(pass_s[6]), 32'h1);

`ifdef BIST_XMASK_EN
        // Masked response FF with mask FE compresses the same as 01.
        applyStimulus(2, 1'b0, 8'hFF, 8'h03, 8'hFE);
        kick(2);
        tick();
        tick();
        tick();
        checkOutput("xmask_done", 32'(done_s[2]), 32'h1);
        checkOutput("xmask_sig", 32'(sig_s[2]), 32'h03);
        checkOutput("xmask_pass", 32'(pass_s[2]), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_bist_harness.md
# tt_bist_harness

Parametrised on-chip built-in self-test harness for Tiny Tapeout user designs. It generates a pseudo-random stimulus stream with a Galois LFSR and drives it into a wrapped design-under-test. It compresses the DUT's responses into a multiple-input signature register (MISR) and compares the result against a golden signature. It sits between the top-level `ui_in`/`uo_out` pins and a DUT core, so the silicon can be checked without an external pattern source.

## Interface
Parameters:
- `WIDTH`, 8: stimulus, response and signature width (2..32).
- `LEN`, 256: vectors per run (1..65535).
- `LAT`, 1: DUT response latency in cycles (0..7).
- `POLY`, 8'h1D: Galois feedback taps, shared by LFSR and MISR (WIDTH bits).
- `SEED`, 8'h01: LFSR start value; a value of 0 is replaced by 1.

Ports:
- `clk`  in  1: the single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: run request, sampled in IDLE or DONE.
- `expected`  in  WIDTH: golden signature, sampled on the DRAIN→DONE transition.
- `resp`  in  WIDTH: DUT response.
- `stim`  out  WIDTH: DUT stimulus.
- `busy`  out  1: high in RUN and DRAIN.
- `done`  out  1: high in DONE.
- `pass`  out  1: signature == expected; valid while done=1.
- `signature`  out  WIDTH: MISR contents.

## Operation
- Step function: step(x) = {x[W-2:0],1'b0} ^ (x[W-1] ? POLY : 0).
- States:
  - IDLE: stim=0, busy=0.
  - RUN: LEN cycles; stim = current LFSR value; LFSR = step(LFSR) each cycle.
  - DRAIN: LAT cycles; stim=0.
  - DONE: done=1; holds signature/pass until the next start or rst.
- Transitions:
  - IDLE/DONE + start=1 → RUN. On that edge: LFSR←SEED, MISR←0, vector counter←0, done←0, pass←0.
  - RUN → DRAIN after the LEN-th vector. When LAT=0, RUN → DONE directly.
  - DRAIN → DONE after LAT cycles. On that edge: pass ← (final signature == expected).
- Compression:
  - A LAT-deep valid shift register tags each stim cycle.
  - On each edge where the tag is set, MISR ← step(MISR) ^ resp_eff, with resp_eff = resp (see Configuration).
  - Exactly LEN responses are compressed; resp is ignored at all other times.
- Boundary rules:
  - start while busy is ignored.
  - The vector counter is WIDTH-independent, 16-bit, with no wrap within a run.
  - LFSR wrap-around within a run is permitted (period 2^WIDTH−1 for a primitive POLY).
  - rst in any state forces IDLE the next cycle and aborts the run. No partial signature is retained.

## Timing
- start sampled high at edge T:
  - Vector k (k=1..LEN) is driven during cycle T+k.
  - Its response is compressed on the edge closing cycle T+k+LAT.
  - busy is high for cycles T+1..T+LEN+LAT.
  - done, pass and final signature are valid from cycle T+LEN+LAT+1.
- Reset values: stim=0, busy=0, done=0, pass=0, signature=0.
- Every output is registered; there is no combinational path from inputs to outputs.

## Configuration
- `BIST_XMASK_EN` defined:
  - Adds input port `xmask` (WIDTH).
  - resp_eff = resp & ~xmask, so unknown or non-deterministic DUT bits are excluded from the signature.
  - xmask is sampled on the same edge as resp.
- Undefined: the port is absent and resp_eff = resp.

## Test plan
All scenarios use WIDTH=8, POLY=8'h1D, SEED=8'h01, LAT=1 unless stated.
- LFSR sequence: LEN=10, resp=0 → stim = 01,02,04,08,10,20,40,80,1D,3A on cycles T+1..T+10; signature=8'h00; with expected=8'h00, pass=1.
- Single-vector MISR: LEN=1, resp=8'h01 constant → signature=8'h01, done=1 at T+3.
- Two-vector MISR: LEN=2, resp=8'h01 constant:
  - expected=8'h03 → pass=1.
  - expected=8'h02 → pass=0.
- Restart and busy rules: start pulsed at T+2 during a LEN=4 run → ignored, done at T+6. A second start in DONE reruns and yields an identical signature.
- Reset mid-run: rst at T+2 of a LEN=8 run → next cycle stim=0, busy=0, signature=0, done=0.
- With BIST_XMASK_EN: LEN=2, resp=8'hFF, xmask=8'hFE → signature=8'h03, identical to the resp=8'h01 case.
